// File: rtl/muldiv_issuer.sv
// ABP initiator issuing MULT/DIV commands to the muldiv units and owning HI/LO.
// Optional MULDIV_DIVZERO_BYPASS_EN resolves divide-by-zero locally.
module muldiv_issuer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        sys_clock_i,
    input  logic        sys_reset_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [31:0] unit_a_o,
    output logic [31:0] unit_b_o,
    output logic        unit_signed_o,
    output logic        mul_req_o,
    input  logic        mul_ack_i,
    input  logic [63:0] mul_product_i,
    output logic        div_req_o,
    input  logic        div_ack_i,
    input  logic [31:0] div_quotient_i,
    input  logic [31:0] div_remainder_i
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MUL,
        WAIT_DIV,
        ZERO
    } state_e;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             mul_req_q, mul_req_d;
    logic             div_req_q, div_req_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] wd_q, wd_d;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        mul_req_d = mul_req_q;
        div_req_d = div_req_q;
        to_d      = 1'b0;
        wd_d      = wd_q;
        unique case (state_q)
            IDLE: begin
                if (hi_we_i) hi_d = wdata_i;
                if (lo_we_i) lo_d = wdata_i;
                if (start_i) begin
                    a_d   = a_i;
                    b_d   = b_i;
                    sgn_d = op_i[0];
                    wd_d  = '0;
`ifdef MULDIV_DIVZERO_BYPASS_EN
                    if (op_i[1] && (b_i == 32'd0)) begin
                        state_d = ZERO;
                    end else
`endif
                    if (op_i[1]) begin
                        div_req_d = ~div_req_q;
                        state_d   = WAIT_DIV;
                    end else begin
                        mul_req_d = ~mul_req_q;
                        state_d   = WAIT_MUL;
                    end
                end
            end
            WAIT_MUL: begin
                if (mul_ack_i == mul_req_q) begin
                    hi_d    = mul_product_i[63:32];
                    lo_d    = mul_product_i[31:0];
                    state_d = IDLE;
                end else if (wd_q == WD_LAST) begin
                    // Resync req to ack so the next issue starts clean
                    mul_req_d = mul_ack_i;
                    to_d      = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            WAIT_DIV: begin
                if (div_ack_i == div_req_q) begin
                    hi_d    = div_remainder_i;
                    lo_d    = div_quotient_i;
                    state_d = IDLE;
                end else if (wd_q == WD_LAST) begin
                    div_req_d = div_ack_i;
                    to_d      = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
`ifdef MULDIV_DIVZERO_BYPASS_EN
            ZERO: begin
                hi_d    = a_q;
                lo_d    = 32'hFFFF_FFFF;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
        if (!sys_reset_i) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            mul_req_q <= 1'b0;
            div_req_q <= 1'b0;
            to_q      <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sgn_q     <= sgn_d;
            mul_req_q <= mul_req_d;
            div_req_q <= div_req_d;
            to_q      <= to_d;
            wd_q      <= wd_d;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign timeout_o     = to_q;
    assign unit_a_o      = a_q;
    assign unit_b_o      = b_q;
    assign unit_signed_o = sgn_q;
    assign mul_req_o     = mul_req_q;
    assign div_req_o     = div_req_q;

endmodule

// File: tb/tb_muldiv_issuer.sv
// Directed bench for muldiv_issuer with 34-cycle ABP responder models.
module tb_muldiv_issuer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi, lo, ua, ub;
    logic        busy, tmo, usgn, mreq, dreq;
    logic        mack, dack;
    logic [63:0] prod;
    logic [31:0] quo, rem;
    logic        mul_en = 1'b1;
    int          mcnt, dcnt;

    int errors = 0;
    int checks = 0;
    logic exp_mreq = 1'b0;
    logic exp_dreq = 1'b0;

    muldiv_issuer dut (
        .sys_clock_i    (clk),
        .sys_reset_i    (rst_n),
        .start_i        (start),
        .op_i           (op),
        .a_i            (a),
        .b_i            (b),
        .hi_we_i        (hi_we),
        .lo_we_i        (lo_we),
        .wdata_i        (wdata),
        .hi_o           (hi),
        .lo_o           (lo),
        .busy_o         (busy),
        .timeout_o      (tmo),
        .unit_a_o       (ua),
        .unit_b_o       (ub),
        .unit_signed_o  (usgn),
        .mul_req_o      (mreq),
        .mul_ack_i      (mack),
        .mul_product_i  (prod),
        .div_req_o      (dreq),
        .div_ack_i      (dack),
        .div_quotient_i (quo),
        .div_remainder_i(rem)
    );

    always #5 clk = ~clk;

    // Multiplier responder: ack follows req 34 edges after the toggle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mack <= 1'b0;
            mcnt <= 0;
            prod <= '0;
        end else if (mul_en && (mreq != mack)) begin
            if (mcnt == 33) begin
                mack <= mreq;
                mcnt <= 0;
                if (usgn)
                    prod <= $signed({{32{ua[31]}}, ua}) * $signed({{32{ub[31]}}, ub});
                else
                    prod <= {32'd0, ua} * {32'd0, ub};
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dack <= 1'b0;
            dcnt <= 0;
            quo  <= '0;
            rem  <= '0;
        end else if (dreq != dack) begin
            if (dcnt == 33) begin
                dack <= dreq;
                dcnt <= 0;
                if (ub == 32'd0) begin
                    quo <= 32'hFFFF_FFFF;
                    rem <= ua;
                end else if (usgn) begin
                    quo <= $signed(ua) / $signed(ub);
                    rem <= $signed(ua) % $signed(ub);
                end else begin
                    quo <= ua / ub;
                    rem <= ua % ub;
                end
            end else begin
                dcnt <= dcnt + 1;
            end
        end else begin
            dcnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] c_op, input logic [31:0] c_a,
                           input logic [31:0] c_b, input bit poke,
                           output int cyc);
        bit stable;
        bit issues;
        issues = 1'b1;
`ifdef MULDIV_DIVZERO_BYPASS_EN
        if (c_op[1] && c_b == 32'd0) issues = 1'b0;
`endif
        @(negedge clk);
        start = 1'b1;
        op = c_op;
        a = c_a;
        b = c_b;
        @(negedge clk);
        start = 1'b0;
        a = ~c_a;
        b = ~c_b;
        if (issues) begin
            if (c_op[1]) exp_dreq = ~exp_dreq;
            else exp_mreq = ~exp_mreq;
        end
        chk("req_toggle", {62'd0, mreq, dreq}, {62'd0, exp_mreq, exp_dreq});
        chk("signed_flag", {63'd0, usgn}, {63'd0, c_op[0]});
        cyc = 0;
        stable = 1'b1;
        while (busy && cyc < 200) begin
            cyc++;
            if (ua !== c_a || ub !== c_b || usgn !== c_op[0]) stable = 1'b0;
            if (mreq !== exp_mreq || dreq !== exp_dreq) stable = 1'b0;
            if (poke && cyc == 10) begin
                start = 1'b1;
                a = 32'd99;
                b = 32'd7;
                op = ~c_op;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("held_stable", {63'd0, stable}, 64'd1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          poke;
    } vec_t;

    vec_t vecs[7];
    int   cyc;
    int   exp_cyc;

    initial begin
        vecs[0] = '{2'd0, 32'd17, 32'd3, 32'h0, 32'd51, 1'b0};
        vecs[1] = '{2'd1, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1};
        vecs[2] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0};
        vecs[3] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0};
        vecs[4] = '{2'd2, 32'd17, 32'd5, 32'd2, 32'd3, 1'b0};
        vecs[5] = '{2'd3, 32'd20, 32'd4, 32'd0, 32'd5, 1'b1};
        vecs[6] = '{2'd3, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 1'b0};

        #12;
        chk("reset_outs", {hi, lo}, 64'd0);
        chk("reset_ctl", {58'd0, busy, tmo, usgn, mreq, dreq, 1'b0}, 64'd0);
        chk("reset_ops", {ua, ub}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].poke, cyc);
            chk($sformatf("busy_cycles[%0d]", i), 64'(cyc), 64'd35);
            chk($sformatf("hi[%0d]", i), {32'd0, hi}, {32'd0, vecs[i].hi});
            chk($sformatf("lo[%0d]", i), {32'd0, lo}, {32'd0, vecs[i].lo});
        end

        // Watchdog abort with a silent multiplier
        mul_en = 1'b0;
        run_cmd(2'd0, 32'd5, 32'd5, 1'b0, cyc);
        chk("timeout_busy", 64'(cyc), 64'd64);
        chk("timeout_pulse", {63'd0, tmo}, 64'd1);
        exp_mreq = 1'b0;
        chk("timeout_resync", {63'd0, mreq}, 64'd0);
        chk("timeout_hilo", {hi, lo}, {32'hFFFF_FFFE, 32'hFFFF_FFFA});
        @(negedge clk);
        chk("timeout_one_cycle", {63'd0, tmo}, 64'd0);
        mul_en = 1'b1;

        lo_we = 1'b1;
        wdata = 32'h0BAD_F00D;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_idle", {32'd0, lo}, {32'd0, 32'h0BAD_F00D});

        // MTHI alongside a DIV start, then an ignored write, then reset
        hi_we = 1'b1;
        wdata = 32'hCAFE_0001;
        start = 1'b1;
        op = 2'd3;
        a = 32'd20;
        b = 32'd4;
        @(negedge clk);
        hi_we = 1'b0;
        start = 1'b0;
        exp_dreq = ~exp_dreq;
        chk("mthi_with_start", {32'd0, hi}, {32'd0, 32'hCAFE_0001});
        chk("start_with_write", {62'd0, busy, dreq}, {62'd0, 1'b1, exp_dreq});
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("write_ignored_busy", {hi, lo}, {32'hCAFE_0001, 32'h0BAD_F00D});
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midop_reset_hilo", {hi, lo}, 64'd0);
        chk("midop_reset_ctl", {59'd0, busy, tmo, usgn, mreq, dreq}, 64'd0);
        chk("midop_reset_ops", {ua, ub}, 64'd0);
        exp_dreq = 1'b0;
        exp_mreq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_cmd(2'd2, 32'd9, 32'd0, 1'b0, cyc);
`ifdef MULDIV_DIVZERO_BYPASS_EN
        exp_cyc = 1;
`else
        exp_cyc = 35;
`endif
        chk("divzero_busy", 64'(cyc), 64'(exp_cyc));
        chk("divzero_hilo", {hi, lo}, {32'd9, 32'hFFFF_FFFF});
        chk("divzero_req", {63'd0, dreq}, {63'd0, exp_dreq});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
